ro_heater_seq: RTL

Stream-side sequencer that drives the RO heater bank's AXI-Stream slave input and monitors its echo output. It takes a host-programmed heat profile: heater count, on-time, off-time and repeat count. It emits the heater start word as a held-valid stream for each on-window and drops valid for each off-window. Returned echo beats are counted and checked. It sits between the kernel control registers and the heater bank, so the heater's start/stop is cycle-accurate rather than host-timed.

---
 rtl/ro_heater_seq_pkg.sv | 18 +
 rtl/ro_echo_monitor.sv | 49 ++++
 rtl/ro_heater_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ro_heater_seq_pkg.sv
// ro_heater_seq shared types and constants.
// State encoding, counter widths, default start word.
package ro_heater_seq_pkg;

  localparam int CNT_W = 32;
  localparam int PER_W = 16;
  localparam int ERR_W = 16;

  localparam int unsigned START_WORD_DEF = 1997;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_OFF  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/ro_echo_monitor.sv
// Echo side of the heater sequencer.
// Accepts echo beats while active and tallies matches/mismatches.
module ro_echo_monitor
  import ro_heater_seq_pkg::*;
#(
  parameter int          C_DATA_WIDTH = 32,
  parameter int unsigned START_WORD   = START_WORD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    active,
  input  logic                    s_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  output logic                    s_tready,
  output logic [CNT_W-1:0]        echo_count,
  output logic [ERR_W-1:0]        echo_err_count
);

  logic beat;
  logic hit;

  assign beat = s_tvalid & s_tready;
  assign hit  = s_tdata == C_DATA_WIDTH'(START_WORD);

  // ready follows sequencer activity; counters saturate and hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_tready       <= 1'b0;
      echo_count     <= '0;
      echo_err_count <= '0;
    end else begin
      s_tready <= active;
      if (clr) begin
        echo_count     <= '0;
        echo_err_count <= '0;
      end else if (beat) begin
        if (hit) begin
          if (~&echo_count)
            echo_count <= echo_count + CNT_W'(1);
        end else begin
          if (~&echo_err_count)
            echo_err_count <= echo_err_count + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ro_heater_seq.sv
// RO heater stream sequencer.
// Plays an on/off heat profile toward the heater bank.
module ro_heater_seq
  import ro_heater_seq_pkg::*;
#(
  parameter int          MAX_RO_HEATERS = 5,
  parameter int          C_DATA_WIDTH   = 32,
  parameter int unsigned START_WORD     = START_WORD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             cfg_heater_num,
  input  logic [31:0]             cfg_on_cycles,
  input  logic [31:0]             cfg_off_cycles,
  input  logic [15:0]             cfg_repeat,
  output logic [31:0]             ro_heater_on_num,
  output logic                    m_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  input  logic                    m_tready,
  input  logic                    s_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  output logic                    s_tready,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             echo_count,
  output logic [15:0]             echo_err_count
);

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0] on_q;
  logic [CNT_W-1:0] off_q;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] off_cnt;
  logic [PER_W-1:0] rep_q;
  logic [PER_W-1:0] period_cnt;
  logic             hs;
  logic             accept;
  logic             on_full;
  logic             on_end;
  logic             off_end;
  logic             last;
  logic [31:0]      heat_max;
  logic [31:0]      heat_clamp;

  assign accept     = (state == ST_IDLE) && start && !abort;
  assign on_full    = on_cnt == on_q - CNT_W'(1);
  assign on_end     = on_full && (hs || m_tready);
  assign off_end    = off_cnt == off_q - CNT_W'(1);
  assign last       = (period_cnt + PER_W'(1)) == rep_q;
  assign heat_max   = 32'(MAX_RO_HEATERS);
  assign heat_clamp = (cfg_heater_num > heat_max)
                    ? heat_max : cfg_heater_num;

  // next state; abort overrides everything
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_on_cycles == '0 || cfg_repeat == '0)
            state_n = ST_DONE;
          else
            state_n = ST_ON;
        end
      end
      ST_ON: begin
        if (on_end) begin
          if (last)
            state_n = ST_DONE;
          else if (off_q != '0)
            state_n = ST_OFF;
          else
            state_n = ST_ON;
        end
      end
      ST_OFF: begin
        if (off_end)
          state_n = ST_ON;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (abort)
      state_n = ST_IDLE;
  end

  // latched profile and window/period counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_q       <= '0;
      off_q      <= '0;
      rep_q      <= '0;
      on_cnt     <= '0;
      off_cnt    <= '0;
      period_cnt <= '0;
      hs         <= 1'b0;
    end else if (accept) begin
      on_q       <= cfg_on_cycles;
      off_q      <= cfg_off_cycles;
      rep_q      <= cfg_repeat;
      on_cnt     <= '0;
      off_cnt    <= '0;
      period_cnt <= '0;
      hs         <= 1'b0;
    end else if (state == ST_ON) begin
      if (on_end) begin
        on_cnt     <= '0;
        hs         <= 1'b0;
        period_cnt <= period_cnt + PER_W'(1);
      end else begin
        if (!on_full)
          on_cnt <= on_cnt + CNT_W'(1);
        if (m_tready)
          hs <= 1'b1;
      end
    end else if (state == ST_OFF) begin
      off_cnt <= off_end ? '0 : off_cnt + CNT_W'(1);
    end
  end

  // state and registered outputs derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      m_tvalid         <= 1'b0;
      m_tdata          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      ro_heater_on_num <= '0;
    end else begin
      state    <= state_n;
      m_tvalid <= state_n == ST_ON;
      m_tdata  <= (state_n == ST_ON)
                ? C_DATA_WIDTH'(START_WORD) : '0;
      busy     <= state_n != ST_IDLE;
      done     <= state_n == ST_DONE;
      if (accept)
        ro_heater_on_num <= heat_clamp;
      else if (state_n == ST_IDLE)
        ro_heater_on_num <= '0;
    end
  end

  ro_echo_monitor #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .START_WORD   (START_WORD)
  ) u_echo (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (accept),
    .active         (state_n != ST_IDLE),
    .s_tvalid       (s_tvalid),
    .s_tdata        (s_tdata),
    .s_tready       (s_tready),
    .echo_count     (echo_count),
    .echo_err_count (echo_err_count)
  );

endmodule
